receiver: RTL and testbench

Serial-to-parallel UART receive stage, the consumer of the `transmitter` serial line. It samples `RXD` at mid-bit using a programmable clock-per-bit divider and recovers 8N1 frames: one start bit, 8 data bits LSB first, one stop bit. Each received byte is presented on `rx_data` with a level valid/acknowledge handshake toward the host logic. Framing errors and overruns are flagged.

---
 rtl/receiver.sv | 108 ++++++++++
 tb/tb_receiver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/receiver.sv
// receiver: 8N1 UART receive stage with mid-bit sampling, valid/ack handoff,
// framing-error pulse and sticky overrun.
module receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RXD,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       framing_error,
  output logic       overrun,
  output logic       rd_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d;
  logic ovr_q, ovr_d;
  logic fe_q, fe_d;
  logic rxd_s;
  assign rxd_s = sync_q[1];
  always_comb begin
    sync_d  = {sync_q[0], RXD};
    state_d = state_q;
    cnt_d   = cnt_q + ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx_ack;
    ovr_d   = ovr_q & ~(valid_q & rx_ack);
    fe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxd_s) state_d = START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        state_d = rxd_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d   = '0;
        shift_d = {rxd_s, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == FULL) begin
        cnt_d = '0;
        if (!rxd_s) begin
          fe_d    = 1'b1;
          state_d = BREAK;
        end else begin
          state_d = IDLE;
          // an ack on the stop-sample edge frees the holding register for this byte
          if (!valid_q || rx_ack) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = 1'b0;
          end else ovr_d = 1'b1;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
    end
  end
  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign overrun       = ovr_q;
  assign framing_error = fe_q;
  assign rd_busy       = state_q != IDLE;
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: directed frames against an event-scheduled timing model of the receiver.
module tb_receiver;
  localparam int N = 16;
  localparam int MAXC = 6000;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic RXD = 1'b1;
  logic rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, framing_error, overrun, rd_busy;
  always #5 clk = ~clk;
  receiver #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .reset(reset), .RXD(RXD), .rx_ack(rx_ack), .rx_data(rx_data),
    .rx_valid(rx_valid), .framing_error(framing_error), .overrun(overrun), .rd_busy(rd_busy)
  );
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit busy_e[MAXC];
  bit good_e[MAXC];
  bit fe_e[MAXC];
  logic [7:0] byte_e[MAXC];
  logic [7:0] data_m = 8'h00;
  logic valid_m = 1'b0, ovr_m = 1'b0, fe_m = 1'b0, busy_m = 1'b0, v0 = 1'b0;
  int vrise_cyc = -1, fe_cyc = -1, fe_count = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got_q[$];
  int ack_reqs = 0, ack_done = 0, vcnt = 0;
  bit auto_ack = 1'b0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask
  // Model: frame outcomes are scheduled by the driver at the cycles the timing rules give;
  // here only the valid/ack/overrun bookkeeping is applied edge by edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset) begin
      data_m = 8'h00; valid_m = 1'b0; ovr_m = 1'b0; fe_m = 1'b0; busy_m = 1'b0;
    end else begin
      v0 = valid_m;
      if (v0 && rx_ack) begin valid_m = 1'b0; ovr_m = 1'b0; end
      fe_m = fe_e[cyc];
      busy_m = busy_e[cyc];
      if (good_e[cyc]) begin
        if (!v0 || rx_ack) begin data_m = byte_e[cyc]; valid_m = 1'b1; ovr_m = 1'b0; end
        else ovr_m = 1'b1;
      end
    end
    #1;
    chk("rx_valid", rx_valid, valid_m);
    chk("rx_data", rx_data, data_m);
    chk("overrun", overrun, ovr_m);
    chk("framing_error", framing_error, fe_m);
    chk("rd_busy", rd_busy, busy_m);
    if (rx_valid && !prev_valid) begin vrise_cyc = cyc; got_q.push_back(rx_data); end
    prev_valid = rx_valid;
    if (framing_error) begin fe_cyc = cyc; fe_count++; end
  end
  initial forever begin
    @(posedge clk);
    #2;
    rx_ack = 1'b0;
    if (ack_reqs != ack_done) begin
      rx_ack = 1'b1; ack_done++; vcnt = 0;
    end else if (auto_ack && rx_valid) begin
      vcnt++;
      if (vcnt == 5) begin rx_ack = 1'b1; vcnt = 0; end
    end else vcnt = 0;
  end
  task automatic hold(input logic v, input int n);
    RXD = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc + 1;
    for (int c = t0 + 2; c < t0 + (stop ? 154 : 160); c++) busy_e[c] = 1'b1;
    if (stop) begin good_e[t0 + 154] = 1'b1; byte_e[t0 + 154] = b; end
    else fe_e[t0 + 154] = 1'b1;
    hold(1'b0, N);
    for (int i = 0; i < 8; i++) hold(b[i], N);
    hold(stop, N);
  endtask
  task automatic ack();
    ack_reqs++;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int t0, t1, h, r, bcnt;
    repeat (3) @(negedge clk);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_valid", rx_valid, 1'b0);
    chk("reset_busy", rd_busy, 1'b0);
    reset = 1'b1;
    hold(1'b1, 2 * N);
    send(8'hA5, 1'b1, t0);
    chk("a5_rise_cycle", vrise_cyc, t0 + 154);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_valid", rx_valid, 1'b1);
    ack();
    chk("a5_acked", rx_valid, 1'b0);
    ack();
    chk("ack_idle_ignored", rx_valid, 1'b0);
    hold(1'b1, N);
    t0 = cyc + 1;
    for (int c = t0 + 2; c < t0 + 10; c++) busy_e[c] = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      RXD = (i < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      bcnt += int'(rd_busy);
    end
    chk("glitch_busy_cycles", bcnt, 8);
    hold(1'b1, 2 * N);
    send(8'h3C, 1'b0, t0);
    h = cyc + 40 * N + 1;
    for (int c = t0 + 160; c <= h + 1; c++) busy_e[c] = 1'b1;
    hold(1'b0, 40 * N / 2);
    chk("break_busy", rd_busy, 1'b1);
    hold(1'b0, 40 * N / 2);
    hold(1'b1, 2 * N);
    chk("fe_cycle", fe_cyc, t0 + 154);
    chk("fe_count", fe_count, 1);
    chk("fe_no_valid", rx_valid, 1'b0);
    send(8'h81, 1'b1, t1);
    chk("after_break_rise", vrise_cyc, t1 + 154);
    chk("after_break_data", rx_data, 8'h81);
    ack();
    hold(1'b1, N);
    send(8'h11, 1'b1, t0);
    send(8'h22, 1'b1, t1);
    hold(1'b1, 4);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_valid", rx_valid, 1'b1);
    ack();
    chk("ovr_ack_valid", rx_valid, 1'b0);
    chk("ovr_ack_flag", overrun, 1'b0);
    hold(1'b1, N);
    got_q.delete();
    auto_ack = 1'b1;
    send(8'h55, 1'b1, t0);
    send(8'hAA, 1'b1, t1);
    hold(1'b1, 2 * N);
    auto_ack = 1'b0;
    chk("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("b2b_first", got_q[0], 8'h55);
      chk("b2b_second", got_q[1], 8'hAA);
    end
    chk("b2b_no_ovr", overrun, 1'b0);
    chk("b2b_acked", rx_valid, 1'b0);
    t0 = cyc + 1;
    for (int c = t0 + 2; c < t0 + 154; c++) busy_e[c] = 1'b1;
    hold(1'b0, N);
    for (int i = 0; i < 4; i++) hold(1'b1, N);
    hold(1'b1, N / 2);
    reset = 1'b0;
    r = cyc;
    for (int c = r + 1; c <= t0 + 160; c++) busy_e[c] = 1'b0;
    #1;
    chk("async_reset_busy", rd_busy, 1'b0);
    chk("async_reset_data", rx_data, 8'h00);
    hold(1'b1, 4);
    reset = 1'b1;
    hold(1'b1, 2 * N);
    send(8'h0F, 1'b1, t1);
    hold(1'b1, N);
    chk("post_reset_data", rx_data, 8'h0F);
    chk("post_reset_valid", rx_valid, 1'b1);
    chk("post_reset_rise", vrise_cyc, t1 + 154);
    chk("post_reset_ovr", overrun, 1'b0);
    chk("post_reset_fe_count", fe_count, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
